led_mode_sequencer: RTL and testbench

Clocked LED mode controller between the board switches/button and the LED bank. A debounced button press steps through four display modes: pass-through, inverted, rotating pattern and blinking. A shared prescaler provides the animation tick. It replaces the combinational switch-to-LED path with a registered, sequenced one.

---
 rtl/led_seq_pkg.sv | 13 +
 rtl/btn_debounce.sv | 63 ++++++
 rtl/led_mode_sequencer.sv | 96 +++++++++
 tb/tb_led_mode_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - display mode enum and shared widths for led_mode_sequencer
package led_seq_pkg;

  localparam int LED_MODE_W = 2;

  typedef enum logic [LED_MODE_W-1:0] {
    MODE_PASS   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BLINK  = 2'd3
  } led_mode_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, optional debouncer and rising-edge press pulse
// Debouncer present only when LED_SEQ_DEBOUNCE_EN is defined; otherwise db is the synchronized level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db,
  output logic press
);

  logic sync1, sync2, db_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          db_r;

  // Counts consecutive disagreeing cycles; any agreeing cycle starts over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      db_r <= 1'b0;
    end else if (sync2 != db_r) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        db_r <= ~db_r;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  assign db = db_r;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES > 0);
  assign db = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_q <= 1'b0;
    else        db_q <= db;
  end

  assign press = db & ~db_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - button-stepped LED mode sequencer: pass, invert, rotate, blink
// Button debouncing is enabled by defining LED_SEQ_DEBOUNCE_EN.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      sw,
  input  logic                  btn,
  output logic [WIDTH-1:0]      led,
  output logic [LED_MODE_W-1:0] mode
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  led_mode_t        state, state_nxt;
  logic             press, btn_db_unused, tick, phase;
  logic [PW-1:0]    pre_cnt;
  logic [WIDTH-1:0] pattern;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .db    (btn_db_unused),
    .press (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MODE_PASS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (press) begin
      case (state)
        MODE_PASS:   state_nxt = MODE_INVERT;
        MODE_INVERT: state_nxt = MODE_ROTATE;
        MODE_ROTATE: state_nxt = MODE_BLINK;
        MODE_BLINK:  state_nxt = MODE_PASS;
      endcase
    end
  end

  always_comb begin
    mode = state;
  end

  // A press restarts the animation period so each mode starts on a full interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           pre_cnt <= '0;
    else if (press || pre_cnt == PRE_LAST) pre_cnt <= '0;
    else                                  pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == PRE_LAST) && !press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= '0;
      phase   <= 1'b1;
    end else begin
      if (press && state_nxt == MODE_ROTATE)
        pattern <= sw;
      else if (tick && state == MODE_ROTATE)
        pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};

      if (press && state_nxt == MODE_BLINK)
        phase <= 1'b1;
      else if (tick && state == MODE_BLINK)
        phase <= ~phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      case (state)
        MODE_PASS:   led <= sw;
        MODE_INVERT: led <= ~sw;
        MODE_ROTATE: led <= pattern;
        MODE_BLINK:  led <= phase ? sw : '0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - self-checking bench for led_mode_sequencer
// Expected button latency follows LED_SEQ_DEBOUNCE_EN.
module tb_led_mode_sequencer;

  localparam int W  = 10;
  localparam int TD = 4;
  localparam int DB = 4;
`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         btn = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] led;
  logic [1:0]   mode;

  int total = 0;
  int bad   = 0;

  led_mode_sequencer #(
    .WIDTH          (W),
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btn   (btn),
    .led   (led),
    .mode  (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
    logic [2*W-1:0] d;
    d = {v, v} << n;
    return d[2*W-1:W];
  endfunction

  // Behavioural model: rotation/blink derived from ticks counted since mode entry.
  logic [W-1:0] led_m = '0;
  logic [W-1:0] entry_sw = '0;
  logic [1:0]   mode_m = '0;
  int unsigned  elapsed = 0;
  int unsigned  nticks = 0;
  logic         btn_last = 1'b0, sync_cur = 1'b0, db_cur = 1'b0, db_prev = 1'b0;
  logic         sync_hist[$];

  initial begin
    logic press_m, tick_m, db_next, all_diff;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        led_m = '0; entry_sw = '0; mode_m = '0; elapsed = 0; nticks = 0;
        btn_last = 1'b0; sync_cur = 1'b0; db_cur = 1'b0; db_prev = 1'b0;
        sync_hist.delete();
      end else begin
        press_m = db_cur & ~db_prev;
        tick_m  = ((elapsed % TD) == TD - 1) && !press_m;
        case (mode_m)
          2'd0:    led_m = sw;
          2'd1:    led_m = ~sw;
          2'd2:    led_m = rotl(entry_sw, int'(nticks % W));
          default: led_m = (nticks % 2 == 0) ? sw : '0;
        endcase
        if (press_m) begin
          mode_m  = mode_m + 2'd1;
          elapsed = 0;
          if (mode_m >= 2'd2) begin
            entry_sw = sw;
            nticks   = 0;
          end
        end else begin
          elapsed++;
          if (tick_m && mode_m >= 2'd2) nticks++;
        end
`ifdef LED_SEQ_DEBOUNCE_EN
        sync_hist.push_back(sync_cur);
        if (sync_hist.size() > DB) void'(sync_hist.pop_front());
        db_next = db_cur;
        if (sync_hist.size() == DB) begin
          all_diff = 1'b1;
          foreach (sync_hist[i]) if (sync_hist[i] == db_cur) all_diff = 1'b0;
          if (all_diff) db_next = ~db_cur;
        end
        db_prev = db_cur;
        db_cur  = db_next;
`else
        db_prev = db_cur;
        db_cur  = btn_last;
`endif
        sync_cur = btn_last;
        btn_last = btn;
      end
    end
  end

  always @(negedge clk) begin
    check("model_led", 32'(led), 32'(led_m));
    check("model_mode", 32'(mode), 32'(mode_m));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn();
    btn = 1'b1;
    cycles(10);
    btn = 1'b0;
    cycles(12);
  endtask

  task automatic wait_mode(input logic [1:0] m);
    int n = 0;
    while (mode !== m && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("wait_mode", 32'(mode), 32'(m));
  endtask

  initial begin
    int first;
    int changes;
    logic [W-1:0] prev;

    rst_n = 1'b0; sw = 10'h3FF; btn = 1'b0;
    cycles(3);
    check("reset_led", 32'(led), 32'h0);
    check("reset_mode", 32'(mode), 32'h0);
    rst_n = 1'b1;
    cycles(1);
    check("pass_led", 32'(led), 32'h3FF);

    sw = 10'b1010101010;
    btn = 1'b1;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (first < 0 && mode == 2'd1) first = i;
    end
    btn = 1'b0;
    check("press_latency", 32'(first - 1), 32'(LAT));
    cycles(20);
    check("invert_mode", 32'(mode), 32'd1);
    check("invert_led", 32'(led), 32'(10'b0101010101));

    btn = 1'b1;
    cycles(3);
    btn = 1'b0;
    cycles(20);
`ifdef LED_SEQ_DEBOUNCE_EN
    check("glitch_mode", 32'(mode), 32'd1);
`else
    check("glitch_mode", 32'(mode), 32'd2);
`endif
    for (int i = 0; i < 4 && mode != 2'd1; i++) press_btn();
    check("to_invert", 32'(mode), 32'd1);

    sw = 10'b0000000001;
    btn = 1'b1;
    wait_mode(2'd2);
    @(negedge clk);
    check("rot_entry", 32'(led), 32'h001);
    btn = 1'b0;
    prev = led;
    changes = 0;
    for (int i = 1; i <= 40; i++) begin
      sw = 10'($urandom);
      @(negedge clk);
      if (led != prev) changes++;
      prev = led;
      if (i == 4) check("rot_step", 32'(led), 32'h002);
    end
    check("rot_wrap", 32'(led), 32'h001);
    check("rot_changes", 32'(changes), 32'd10);

    sw = 10'b1111100000;
    btn = 1'b1;
    wait_mode(2'd3);
    @(negedge clk);
    check("blink_on", 32'(led), 32'h3E0);
    btn = 1'b0;
    cycles(4);
    check("blink_off", 32'(led), 32'h000);
    cycles(4);
    check("blink_on2", 32'(led), 32'h3E0);

    btn = 1'b1;
    wait_mode(2'd0);
    @(negedge clk);
    check("wrap_led", 32'(led), 32'h3E0);
    btn = 1'b0;
    cycles(12);

    sw = 10'b0000000001;
    press_btn();
    press_btn();
    check("rot_again", 32'(mode), 32'd2);
    cycles(5);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h000);
    check("async_mode", 32'(mode), 32'h0);
    cycles(3);
    rst_n = 1'b1;
    sw = 10'h155;
    cycles(1);
    check("post_reset_mode", 32'(mode), 32'h0);
    check("post_reset_led", 32'(led), 32'h155);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule
